cfg_mgmt_req_seq: RTL
=====================

# cfg_mgmt_req_seq

Queued sequencer that sits directly upstream of the root port's configuration management interface. It accepts local config-space read and write requests from the test program over a valid/ready channel and buffers them in a small FIFO. It then drives them one at a time onto the `cfg_mgmt_*` strobes, waits for `cfg_mgmt_read_write_done` under a timeout, and returns one response per request on a valid/ready response channel.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: request FIFO entries; power of two, minimum 2.
- `TIMEOUT_CYC`, default 1023: number of WAIT cycles without done before the transaction is aborted; range 1..65535.

Ports:
- `user_clk` in 1: sole clock; all logic on its rising edge.
- `user_reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: FIFO can accept.
- `req_write` in 1: 1 = write, 0 = read.
- `req_type1` in 1: request targets a type-1 register.
- `req_addr` in 10: DW address.
- `req_data` in 32: write data.
- `req_be` in 4: byte enables.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed.
- `rsp_write` out 1: echo of `req_write`.
- `rsp_timeout` out 1: transaction aborted by the timeout.
- `rsp_data` out 32: read data.
- `busy` out 1: high when state ≠ IDLE or the FIFO is non-empty.
- `cfg_mgmt_addr` out 10, `cfg_mgmt_write` out 1, `cfg_mgmt_read` out 1, `cfg_mgmt_write_data` out 32, `cfg_mgmt_byte_enable` out 4, `cfg_mgmt_type1_cfg_reg_access` out 1: management strobes, all registered.
- `cfg_mgmt_read_data` in 32, `cfg_mgmt_read_write_done` in 1: completion from the core.

## Operation
- Each FIFO entry holds {write, type1, addr, data, be}, which is 48 bits.
- `req_ready` = !full, computed from the registered count. A push occurs on `req_valid && req_ready`.
- Push and pop in the same cycle are legal; the count is unchanged.
- There is no bypass of a full FIFO.

FSM states are IDLE, WAIT, RESP and GAP.
- **IDLE:** if the FIFO is non-empty, pop the head entry and load the strobes, then go to WAIT.
  - Write requests: `cfg_mgmt_write`=1, `cfg_mgmt_read`=0, and `cfg_mgmt_write_data`/`cfg_mgmt_byte_enable` are loaded.
  - Read requests: `cfg_mgmt_read`=1, `cfg_mgmt_write`=0, and `cfg_mgmt_byte_enable`=4'h0.
  - `cfg_mgmt_addr` and `cfg_mgmt_type1_cfg_reg_access` are loaded in both cases.
  - The timeout counter is cleared.
- **WAIT:** strobes and address are held stable. The counter increments every cycle.
  - On `cfg_mgmt_read_write_done`=1:
    - For a read, capture `cfg_mgmt_read_data` into `rsp_data`; for a write, set `rsp_data`=0.
    - Set `rsp_timeout`=0.
    - Clear the strobes, addr, be and type1 to 0. `cfg_mgmt_write_data` holds its last value.
    - Go to RESP.
  - If the counter reaches `TIMEOUT_CYC` with done still low: clear the strobes the same way, set `rsp_data`=32'hFFFF_FFFF and `rsp_timeout`=1, and go to RESP.
  - If done and the timeout coincide, done wins.
- **RESP:** `rsp_valid`=1. Hold `rsp_data`, `rsp_write` and `rsp_timeout` stable until `rsp_valid && rsp_ready`, then go to GAP.
- **GAP:** exactly 2 idle cycles with all strobes low, then go to IDLE.
- `cfg_mgmt_read_write_done` is ignored in every state except WAIT, including a late done after a timeout.
- Reset values: all outputs are 0, except `req_ready`=1. FIFO empty, state IDLE, counter 0.
- Reset mid-operation: the asynchronous clear takes effect immediately and drops the strobes. In-flight and queued requests are discarded and no response is produced.

## Timing
- A request accepted at edge E0 into an empty idle block has strobes high after edge E1.
- Done is sampled from the first edge after the strobes rise. A done observed at edge Ed clears the strobes and raises `rsp_valid` after Ed.
- Minimum cost per transaction: 1 cycle IDLE + ≥1 cycle WAIT + ≥1 cycle RESP + 2 cycles GAP. That gives ≥5 cycles from strobe rise to the next strobe rise, with back-to-back requests.
- Timeout: strobes are high for exactly `TIMEOUT_CYC` cycles, then `rsp_valid` rises.
- `rsp_ready` held low stalls the FSM in RESP indefinitely. The FIFO keeps accepting requests until full.
- Requests are issued and responded to strictly in FIFO order.

## Test plan
- **Single read:** push read addr 10'h004. Core returns done 3 cycles after strobe with data 32'h10EE_9038. Expect `cfg_mgmt_read`=1 for exactly 3 cycles with addr 10'h004 and be 0, then `rsp_valid` with `rsp_data`=32'h10EE_9038, `rsp_timeout`=0.
- **Single write:** push write addr 10'h001, data 32'h0000_0007, be 4'hF. Expect the strobe fields stable until done. On exit, `cfg_mgmt_addr`=0 and be=0, and `rsp_data`=0. The next strobe comes no earlier than 2 cycles after the response handshake.
- **Backpressure:** push 5 requests with `FIFO_DEPTH`=4 and `rsp_ready`=0. Expect `req_ready`=0 once 4 are queued behind the in-flight one. Then release `rsp_ready`=1 and expect 5 responses in order.
- **Timeout:** with `TIMEOUT_CYC`=8, issue a read and never assert done. Expect the strobe high for 8 cycles, then `rsp_data`=32'hFFFF_FFFF and `rsp_timeout`=1. A late done pulse during GAP must have no effect.
- **Coincident done/timeout:** done arrives exactly on the timeout cycle. Expect `rsp_timeout`=0 and real data returned.
- **Reset mid-WAIT:** assert `user_reset_n`=0 asynchronously while in WAIT with 2 requests queued. Expect the strobes to drop without a clock edge, no `rsp_valid`, and after release `busy`=0 and `req_ready`=1.

Source files
------------

// File: rtl/cfg_mgmt_req_seq.sv
`default_nettype none
// ============================================================================
//  Module      : cfg_mgmt_req_seq
//  Description : Queued config-space request sequencer. It buffers read and
//                write requests and drives them one at a time onto the
//                cfg_mgmt strobes, then returns one response per request.
//  Revision    : 1.0 - initial release
// ============================================================================
module cfg_mgmt_req_seq #(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic        user_clk,
    input  logic        user_reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_type1,
    input  logic [9:0]  req_addr,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_write,
    output logic        rsp_timeout,
    output logic [31:0] rsp_data,
    output logic        busy,
    output logic [9:0]  cfg_mgmt_addr,
    output logic        cfg_mgmt_write,
    output logic        cfg_mgmt_read,
    output logic [31:0] cfg_mgmt_write_data,
    output logic [3:0]  cfg_mgmt_byte_enable,
    output logic        cfg_mgmt_type1_cfg_reg_access,
    input  logic [31:0] cfg_mgmt_read_data,
    input  logic        cfg_mgmt_read_write_done
);

    localparam int               c_AW       = $clog2(FIFO_DEPTH);
    localparam logic [c_AW-1:0]  c_PTR_ONE  = 1;
    localparam logic [c_AW:0]    c_CNT_ONE  = 1;
    localparam logic [c_AW:0]    c_CNT_FULL = (c_AW+1)'(FIFO_DEPTH);
    localparam logic [15:0]      c_TMO_LAST = 16'(TIMEOUT_CYC - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;
    localparam logic [1:0] c_ST_GAP  = 2'd3;

    // Entry layout: {write, type1, addr[9:0], data[31:0], be[3:0]}
    logic [47:0]     r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic [47:0]     w_head;

    logic [1:0]  r_state,       w_nxt_state;
    logic [15:0] r_tmo_cnt,     w_nxt_tmo_cnt;
    logic        r_gap,         w_nxt_gap;
    logic        r_rsp_valid,   w_nxt_rsp_valid;
    logic        r_rsp_write,   w_nxt_rsp_write;
    logic        r_rsp_timeout, w_nxt_rsp_timeout;
    logic [31:0] r_rsp_data,    w_nxt_rsp_data;
    logic [9:0]  r_mg_addr,     w_nxt_mg_addr;
    logic        r_mg_write,    w_nxt_mg_write;
    logic        r_mg_read,     w_nxt_mg_read;
    logic [31:0] r_mg_wdata,    w_nxt_mg_wdata;
    logic [3:0]  r_mg_be,       w_nxt_mg_be;
    logic        r_mg_type1,    w_nxt_mg_type1;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_CNT_FULL);
    assign w_push    = req_valid && !w_full;
    assign w_head    = r_mem[r_rd_ptr];
    assign req_ready = !w_full;

    always_ff @(posedge user_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {req_write, req_type1, req_addr, req_data, req_be};
        end
    end

    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_pop             = 1'b0;
        w_nxt_state       = r_state;
        w_nxt_tmo_cnt     = r_tmo_cnt;
        w_nxt_gap         = r_gap;
        w_nxt_rsp_valid   = r_rsp_valid;
        w_nxt_rsp_write   = r_rsp_write;
        w_nxt_rsp_timeout = r_rsp_timeout;
        w_nxt_rsp_data    = r_rsp_data;
        w_nxt_mg_addr     = r_mg_addr;
        w_nxt_mg_write    = r_mg_write;
        w_nxt_mg_read     = r_mg_read;
        w_nxt_mg_wdata    = r_mg_wdata;
        w_nxt_mg_be       = r_mg_be;
        w_nxt_mg_type1    = r_mg_type1;
        case (r_state)
            c_ST_IDLE: begin
                if (!w_empty) begin
                    w_pop           = 1'b1;
                    w_nxt_mg_write  = w_head[47];
                    w_nxt_mg_read   = !w_head[47];
                    w_nxt_mg_type1  = w_head[46];
                    w_nxt_mg_addr   = w_head[45:36];
                    w_nxt_mg_be     = 4'h0;
                    if (w_head[47]) begin
                        w_nxt_mg_wdata = w_head[35:4];
                        w_nxt_mg_be    = w_head[3:0];
                    end
                    w_nxt_rsp_write = w_head[47];
                    w_nxt_tmo_cnt   = '0;
                    w_nxt_state     = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                w_nxt_tmo_cnt = r_tmo_cnt + 16'd1;
                // Done is checked first so a completion on the last cycle still wins.
                if (cfg_mgmt_read_write_done || (r_tmo_cnt == c_TMO_LAST)) begin
                    w_nxt_mg_write  = 1'b0;
                    w_nxt_mg_read   = 1'b0;
                    w_nxt_mg_addr   = '0;
                    w_nxt_mg_be     = '0;
                    w_nxt_mg_type1  = 1'b0;
                    w_nxt_rsp_valid = 1'b1;
                    w_nxt_state     = c_ST_RESP;
                    if (cfg_mgmt_read_write_done) begin
                        w_nxt_rsp_timeout = 1'b0;
                        w_nxt_rsp_data    = r_rsp_write ? 32'h0 : cfg_mgmt_read_data;
                    end else begin
                        w_nxt_rsp_timeout = 1'b1;
                        w_nxt_rsp_data    = 32'hFFFF_FFFF;
                    end
                end
            end
            c_ST_RESP: begin
                if (rsp_ready) begin
                    w_nxt_rsp_valid = 1'b0;
                    w_nxt_gap       = 1'b0;
                    w_nxt_state     = c_ST_GAP;
                end
            end
            c_ST_GAP: begin
                w_nxt_gap = 1'b1;
                if (r_gap) w_nxt_state = c_ST_IDLE;
            end
            default: w_nxt_state = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            r_state       <= c_ST_IDLE;
            r_tmo_cnt     <= '0;
            r_gap         <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_write   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_data    <= '0;
            r_mg_addr     <= '0;
            r_mg_write    <= 1'b0;
            r_mg_read     <= 1'b0;
            r_mg_wdata    <= '0;
            r_mg_be       <= '0;
            r_mg_type1    <= 1'b0;
        end else begin
            r_state       <= w_nxt_state;
            r_tmo_cnt     <= w_nxt_tmo_cnt;
            r_gap         <= w_nxt_gap;
            r_rsp_valid   <= w_nxt_rsp_valid;
            r_rsp_write   <= w_nxt_rsp_write;
            r_rsp_timeout <= w_nxt_rsp_timeout;
            r_rsp_data    <= w_nxt_rsp_data;
            r_mg_addr     <= w_nxt_mg_addr;
            r_mg_write    <= w_nxt_mg_write;
            r_mg_read     <= w_nxt_mg_read;
            r_mg_wdata    <= w_nxt_mg_wdata;
            r_mg_be       <= w_nxt_mg_be;
            r_mg_type1    <= w_nxt_mg_type1;
        end
    end

    assign rsp_valid                     = r_rsp_valid;
    assign rsp_write                     = r_rsp_write;
    assign rsp_timeout                   = r_rsp_timeout;
    assign rsp_data                      = r_rsp_data;
    assign busy                          = (r_state != c_ST_IDLE) || !w_empty;
    assign cfg_mgmt_addr                 = r_mg_addr;
    assign cfg_mgmt_write                = r_mg_write;
    assign cfg_mgmt_read                 = r_mg_read;
    assign cfg_mgmt_write_data           = r_mg_wdata;
    assign cfg_mgmt_byte_enable          = r_mg_be;
    assign cfg_mgmt_type1_cfg_reg_access = r_mg_type1;

endmodule
`default_nettype wire
